// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT-line framers.
//   CRC16_POLY / CRC16_W : CCITT CRC16 used on each DAT line
//   state_t              : framer state encoding
package sd_dat_pkg;

  localparam int unsigned CRC16_W    = 16;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    END
  } state_t;

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16 (CCITT, MSB first, init 0) shared by the RX and TX framers.
// Ports:
//   clk   in  clock
//   reset in  synchronous active-high reset, clears crc
//   clr   in  synchronous clear, clears crc
//   en    in  shift one bit of din into the LFSR
//   din   in  serial data bit
//   crc   out current CRC register
module sd_crc16
  import sd_dat_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic               din,
  output logic [CRC16_W-1:0] crc
);

  logic w_fb;

  assign w_fb = crc[CRC16_W-1] ^ din;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC16_W-2:0], 1'b0} ^ ({CRC16_W{w_fb}} & CRC16_POLY);
    end
  end

endmodule

// File: rtl/dat_rx_frame.sv
// Receive-side framer for one SD DAT0 data block.
// Waits for the start bit, forwards BLOCK_BYTES*8 data bits on bit_out/bit_valid,
// then captures the 16-bit CRC and the end bit and reports status with a done pulse.
// Ports:
//   clk          in  SD clock, one DAT0 bit per edge
//   reset        in  synchronous active-high reset
//   rx_start     in  1-cycle arm pulse (ignored while busy)
//   abort        in  synchronous abort back to IDLE, no done
//   dat_in       in  DAT0 line (idle high)
//   bit_out      out registered data bit for the downstream s->p stage
//   bit_valid    out qualifier for bit_out
//   busy         out high whenever not IDLE
//   done         out 1-cycle pulse at block end or timeout
//   crc_err      out CRC mismatch flag, held until next accepted rx_start
//   end_err      out end bit low flag, held until next accepted rx_start
//   timeout_err  out start-bit timeout flag, held until next accepted rx_start
module dat_rx_frame
  import sd_dat_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_start,
  input  logic abort,
  input  logic dat_in,
  output logic bit_out,
  output logic bit_valid,
  output logic busy,
  output logic done,
  output logic crc_err,
  output logic end_err,
  output logic timeout_err
);

  localparam int unsigned DATA_BITS = BLOCK_BYTES * 8;
  localparam int unsigned BC_W      = $clog2(DATA_BITS) + 1;
  localparam int unsigned TC_W      = $clog2(TIMEOUT + 1);

  state_t               r_state;
  logic [BC_W-1:0]      r_bit_cnt;
  logic [TC_W-1:0]      r_tmo_cnt;
  logic [3:0]           r_crc_cnt;
  logic [CRC16_W-1:0]   r_rx_crc;
  logic [CRC16_W-1:0]   w_calc_crc;
  logic                 w_crc_clr;
  logic                 w_crc_en;

  // CRC restarts on the start bit and only sees data bits; abort freezes it.
  assign w_crc_clr = (r_state == WAIT_START) && !dat_in && !abort;
  assign w_crc_en  = (r_state == DATA) && !abort;
  assign busy      = (r_state != IDLE);

  sd_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (w_crc_clr),
    .en    (w_crc_en),
    .din   (dat_in),
    .crc   (w_calc_crc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_crc_cnt   <= '0;
      r_rx_crc    <= '0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      done        <= 1'b0;
      crc_err     <= 1'b0;
      end_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else if (abort) begin
      r_state   <= IDLE;
      bit_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_start) begin
            r_state     <= WAIT_START;
            r_tmo_cnt   <= '0;
            crc_err     <= 1'b0;
            end_err     <= 1'b0;
            timeout_err <= 1'b0;
          end
        end

        WAIT_START: begin
          if (!dat_in) begin
            r_state   <= DATA;
            r_bit_cnt <= '0;
          end else if (r_tmo_cnt == TC_W'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        DATA: begin
          bit_out   <= dat_in;
          bit_valid <= 1'b1;
          if (r_bit_cnt == BC_W'(DATA_BITS - 1)) begin
            r_state   <= CRC;
            r_bit_cnt <= '0;
            r_crc_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

        CRC: begin
          r_rx_crc <= {r_rx_crc[CRC16_W-2:0], dat_in};
          if (r_crc_cnt == 4'd15) begin
            r_state <= END;
          end else begin
            r_crc_cnt <= r_crc_cnt + 1'b1;
          end
        end

        END: begin
          end_err <= !dat_in;
          crc_err <= (r_rx_crc != w_calc_crc);
          done    <= 1'b1;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dat_rx_frame.sv
module tb_dat_rx_frame;

  localparam int unsigned NBITS = 4096;

  logic clk = 1'b0;
  logic reset, rx_start, abort, dat_in;
  logic bit_out, bit_valid, busy, done, crc_err, end_err, timeout_err;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int dcount = 0;

  always #5 clk = ~clk;

  dat_rx_frame #(.BLOCK_BYTES(512), .TIMEOUT(1023)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .rx_start    (rx_start),
    .abort       (abort),
    .dat_in      (dat_in),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .busy        (busy),
    .done        (done),
    .crc_err     (crc_err),
    .end_err     (end_err),
    .timeout_err (timeout_err)
  );

  always @(negedge clk) begin
    if (bit_valid === 1'b1) vcount++;
    if (done === 1'b1) dcount++;
  end

  typedef struct {
    string       tag;
    int          pat;
    logic [15:0] crc;
    logic        end_bit;
    int          mid;
    logic        exp_crc_err;
    logic        exp_end_err;
  } vec_t;

  vec_t tbl[4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit data_bit(input int pat, input int unsigned idx);
    logic [7:0] b;
    if (pat == 0) b = 8'hFF;
    else b = 8'(((idx / 8) * 37) + 11);
    return b[7 - (idx % 8)];
  endfunction

  function automatic logic [15:0] crc_of(input int pat);
    logic [15:0] c;
    bit fb;
    c = 16'h0000;
    for (int unsigned i = 0; i < NBITS; i++) begin
      fb = c[15] ^ data_bit(pat, i);
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic arm_and_start;
    rx_start = 1'b1;
    dat_in   = 1'b1;
    tick;
    rx_start = 1'b0;
    repeat (3) tick;
    dat_in = 1'b0;
    tick;
  endtask

  task automatic run_block(input string tag, input int pat, input logic [15:0] crc,
                           input logic end_bit, input int mid,
                           input logic exp_ce, input logic exp_ee);
    int v0, d0, bad;
    v0 = vcount; d0 = dcount; bad = 0;
    rx_start = 1'b1;
    dat_in   = 1'b1;
    tick;
    rx_start = 1'b0;
    chk({tag, " busy after arm"}, 32'(busy), 32'd1);
    chk({tag, " flags cleared on arm"}, 32'({crc_err, end_err, timeout_err}), 32'd0);
    repeat (3) tick;
    dat_in = 1'b0;
    tick;
    for (int i = 0; i < int'(NBITS); i++) begin
      dat_in = data_bit(pat, i);
      if (i == mid) rx_start = 1'b1;
      tick;
      rx_start = 1'b0;
      if (bit_valid !== 1'b1 || bit_out !== dat_in) bad++;
    end
    for (int i = 0; i < 16; i++) begin
      dat_in = crc[15 - i];
      tick;
    end
    dat_in = end_bit;
    tick;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " crc_err"}, 32'(crc_err), 32'(exp_ce));
    chk({tag, " end_err"}, 32'(end_err), 32'(exp_ee));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
    dat_in = 1'b1;
    tick;
    chk({tag, " done single pulse"}, 32'(done), 32'd0);
    chk({tag, " busy after end"}, 32'(busy), 32'd0);
    chk({tag, " bit_valid count"}, 32'(vcount - v0), 32'(NBITS));
    chk({tag, " done count"}, 32'(dcount - d0), 32'd1);
    chk({tag, " data bits"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int v0, d0, early;

    tbl[0] = '{"ff_good",  0, 16'h7FA1, 1'b1, -1,   1'b0, 1'b0};
    tbl[1] = '{"pat_good", 1, 16'h0000, 1'b1, 1500, 1'b0, 1'b0};
    tbl[2] = '{"crc_flip", 0, 16'h7FA0, 1'b1, -1,   1'b1, 1'b0};
    tbl[3] = '{"end_zero", 0, 16'h7FA1, 1'b0, -1,   1'b0, 1'b1};
    tbl[1].crc = crc_of(1);

    reset = 1'b1; rx_start = 1'b0; abort = 1'b0; dat_in = 1'b1;
    repeat (3) tick;
    chk("reset outputs", 32'({bit_out, bit_valid, busy, done, crc_err, end_err, timeout_err}), 32'd0);
    reset = 1'b0;
    tick;

    foreach (tbl[k])
      run_block(tbl[k].tag, tbl[k].pat, tbl[k].crc, tbl[k].end_bit, tbl[k].mid,
                tbl[k].exp_crc_err, tbl[k].exp_end_err);

    // Flag is held in IDLE, then cleared by reset.
    repeat (5) tick;
    chk("end_err held", 32'(end_err), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("end_err cleared by reset", 32'(end_err), 32'd0);
    tick;

    // Start-bit timeout.
    v0 = vcount; d0 = dcount; early = 0;
    rx_start = 1'b1;
    dat_in   = 1'b1;
    tick;
    rx_start = 1'b0;
    for (int k = 1; k < 1024; k++) begin
      tick;
      if (done !== 1'b0 || timeout_err !== 1'b0) early++;
    end
    chk("timeout early", 32'(early), 32'd0);
    tick;
    chk("timeout done", 32'(done), 32'd1);
    chk("timeout_err", 32'(timeout_err), 32'd1);
    tick;
    chk("timeout busy", 32'(busy), 32'd0);
    chk("timeout no valid", 32'(vcount - v0), 32'd0);
    chk("timeout done count", 32'(dcount - d0), 32'd1);

    // Reset after 100 data bits.
    d0 = dcount;
    arm_and_start();
    for (int i = 0; i < 100; i++) begin
      dat_in = 1'b1;
      tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid reset outputs", 32'({busy, bit_valid, done, crc_err, end_err, timeout_err}), 32'd0);
    dat_in = 1'b1;
    repeat (5) tick;
    chk("mid reset no done", 32'(dcount - d0), 32'd0);
    run_block("after_reset", 0, 16'h7FA1, 1'b1, -1, 1'b0, 1'b0);

    // Abort at bit 2000.
    v0 = vcount; d0 = dcount;
    arm_and_start();
    for (int i = 0; i < 2000; i++) begin
      dat_in = 1'b1;
      tick;
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort outputs", 32'({busy, bit_valid, done}), 32'd0);
    repeat (5) tick;
    chk("abort no done", 32'(dcount - d0), 32'd0);
    chk("abort valid count", 32'(vcount - v0), 32'd2000);
    run_block("after_abort", 0, 16'h7FA1, 1'b1, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
